// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Includes the md_op codes, default latencies and FSM states.
package md_sequencer_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath producing the {hi,lo} result.
// Signed divide works on magnitudes, then restores the quotient and remainder signs.
module md_alu
   import md_sequencer_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [63:0] result
);

   logic [63:0] prod_signed;
   logic [63:0] prod_unsigned;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_signed;
   logic [31:0] r_signed;
   logic [31:0] q_unsigned;
   logic [31:0] r_unsigned;
   logic        b_zero;

   assign prod_signed   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_unsigned = {32'd0, A} * {32'd0, B};

   assign b_zero = (B == 32'd0);
   assign a_mag  = A[31] ? (32'd0 - A) : A;
   assign b_mag  = B[31] ? (32'd0 - B) : B;
   assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
   assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);

   // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates to itself, remainder 0.
   assign q_signed   = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
   assign r_signed   = A[31] ? (32'd0 - r_mag) : r_mag;
   assign q_unsigned = b_zero ? 32'd0 : (A / B);
   assign r_unsigned = b_zero ? 32'd0 : (A % B);

   always_comb begin
      result = 64'd0;
      case (op)
         OP_MULT:  result = prod_signed;
         OP_MULTU: result = prod_unsigned;
         OP_DIV: begin
            if (b_zero) begin
               result = {A, 32'hFFFF_FFFF};
            end else begin
               result = {r_signed, q_signed};
            end
         end
         OP_DIVU: begin
            if (b_zero) begin
               result = {A, 32'hFFFF_FFFF};
            end else begin
               result = {r_unsigned, q_unsigned};
            end
         end
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models fixed latency, and stalls
// md-class instructions in ID while an operation is in flight.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        id_md_use,
   output logic        start,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] alu_result;

   md_alu u_alu (
      .op     (md_op),
      .A      (A),
      .B      (B),
      .result (alu_result)
   );

   assign busy  = (state_q == ST_BUSY);
   assign start = md_valid & md_is_arith(md_op) & ~busy;
   assign stall = id_md_use & (start | busy);
   assign hi    = hi_q;
   assign lo    = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pend_d  = alu_result;
               cnt_d   = md_is_div(md_op) ? DIV_LAT : MULT_LAT;
               state_d = ST_BUSY;
            end else if (md_valid && (md_op == OP_MTHI)) begin
               hi_d = A;
            end else if (md_valid && (md_op == OP_MTLO)) begin
               lo_d = A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // Any md_valid seen here is ignored; the stall keeps it from happening.
            if (cnt_q == 4'd1) begin
               hi_d    = pend_q[63:32];
               lo_d    = pend_q[31:0];
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         pend_q  <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed table, randomized ops
// against an arithmetic reference model, and reset-abort sequences.
module tb_md_sequencer;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        id_md_use;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int passes = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   typedef struct {
      logic        v;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        id;
      int          n;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t tbl[13];

   always #5 clk = ~clk;

   md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .reset     (reset),
      .md_valid  (md_valid),
      .md_op     (md_op),
      .A         (A),
      .B         (B),
      .id_md_use (id_md_use),
      .start     (start),
      .busy      (busy),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo)
   );

   // An md write op must never reach EX while an operation is in flight.
   always @(posedge clk) begin
      assert (reset || !(md_valid && busy))
         else $error("FAIL md_valid_while_busy: md_valid=1 busy=1 required no overlap");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Reference: result and latency straight from the arithmetic definitions.
   function automatic void ref_op(input logic v, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] oh, input logic [31:0] ol,
                                  output logic [31:0] nh, output logic [31:0] nl,
                                  output int n);
      longint sa, sb, q, r;
      logic [63:0] p;
      nh = oh;
      nl = ol;
      n  = 0;
      sa = $signed(a);
      sb = $signed(b);
      if (v) begin
         case (op)
            3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; n = MC; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0]; n = MC; end
            3'd3: begin
               n = DC;
               if (b == 32'd0) begin
                  nh = a; nl = 32'hFFFF_FFFF;
               end else begin
                  q = sa / sb; r = sa % sb;
                  p = q; nl = p[31:0];
                  p = r; nh = p[31:0];
               end
            end
            3'd4: begin
               n = DC;
               if (b == 32'd0) begin
                  nh = a; nl = 32'hFFFF_FFFF;
               end else begin
                  nl = a / b; nh = a % b;
               end
            end
            3'd5: nh = a;
            3'd6: nl = a;
            default: n = 0;
         endcase
      end
   endfunction

   task automatic run_op(input string nm, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic id,
                         input int n, input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] h0, l0;
      logic        st;
      h0 = hi_m;
      l0 = lo_m;
      st = (n > 0);
      @(negedge clk);
      md_valid = v; md_op = op; A = a; B = b; id_md_use = id;
      #1;
      chk({nm, ".start"}, {31'd0, start}, {31'd0, st});
      chk({nm, ".stall_T"}, {31'd0, stall}, {31'd0, id & st});
      @(negedge clk);
      md_valid = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
      for (int i = 1; i <= n; i++) begin
         chk({nm, ".busy"}, {31'd0, busy}, 32'd1);
         chk({nm, ".stall_busy"}, {31'd0, stall}, {31'd0, id});
         chk({nm, ".hi_hold"}, hi, h0);
         chk({nm, ".lo_hold"}, lo, l0);
         @(negedge clk);
      end
      chk({nm, ".busy_end"}, {31'd0, busy}, 32'd0);
      chk({nm, ".stall_end"}, {31'd0, stall}, 32'd0);
      chk({nm, ".hi"}, hi, eh);
      chk({nm, ".lo"}, lo, el);
      hi_m = eh;
      lo_m = el;
      id_md_use = 1'b0;
   endtask

   initial begin
      logic [31:0] rh, rl, ra, rb;
      logic [2:0]  rop;
      logic        rv;
      int          rn;

      tbl[0]  = '{1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 32'hDEAD_BEEF, 32'd0};
      tbl[1]  = '{1'b1, 3'd6, 32'd5, 32'd0, 1'b0, 0, 32'hDEAD_BEEF, 32'd5};
      tbl[2]  = '{1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      tbl[3]  = '{1'b1, 3'd4, 32'd100, 32'd7, 1'b1, DC, 32'd2, 32'd14};
      tbl[4]  = '{1'b1, 3'd7, 32'd1, 32'd1, 1'b1, 0, 32'd2, 32'd14};
      tbl[5]  = '{1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[6]  = '{1'b1, 3'd3, 32'h0000_1234, 32'd0, 1'b0, DC, 32'h0000_1234, 32'hFFFF_FFFF};
      tbl[7]  = '{1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'd0, 32'h8000_0000};
      tbl[8]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, MC, 32'd1, 32'hFFFF_FFFE};
      tbl[9]  = '{1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, MC, 32'h4000_0000, 32'd0};
      tbl[10] = '{1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 0, 32'h4000_0000, 32'd0};
      tbl[11] = '{1'b0, 3'd1, 32'd3, 32'd3, 1'b1, 0, 32'h4000_0000, 32'd0};
      tbl[12] = '{1'b1, 3'd4, 32'd7, 32'd100, 1'b0, DC, 32'd7, 32'd0};

      reset = 1'b1; md_valid = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; id_md_use = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.start", {31'd0, start}, 32'd0);
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);

      for (int i = 0; i < 13; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].id, tbl[i].n, tbl[i].eh, tbl[i].el);
      end

      for (int i = 0; i < 40; i++) begin
         rv  = ($urandom_range(0, 5) != 0);
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 7) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if ($urandom_range(0, 3) == 0) begin
            rb = 32'($urandom_range(1, 20));
         end
         ref_op(rv, rop, ra, rb, hi_m, lo_m, rh, rl, rn);
         run_op($sformatf("rnd%0d", i), rv, rop, ra, rb, 1'($urandom_range(0, 1)), rn, rh, rl);
      end

      // Reset in busy cycle 3 aborts the multu with no later commit.
      @(negedge clk);
      md_valid = 1'b1; md_op = 3'd2; A = 32'hFFFF_FFFF; B = 32'd2;
      @(negedge clk);
      md_valid = 1'b0; md_op = 3'd0;
      repeat (2) @(negedge clk);
      chk("abort.busy_c3", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.busy", {31'd0, busy}, 32'd0);
      chk("abort.hi", hi, 32'd0);
      chk("abort.lo", lo, 32'd0);
      repeat (8) @(negedge clk);
      chk("abort.busy_late", {31'd0, busy}, 32'd0);
      chk("abort.hi_late", hi, 32'd0);
      chk("abort.lo_late", lo, 32'd0);
      hi_m = 32'd0;
      lo_m = 32'd0;

      // Reset beats a simultaneous mthi.
      run_op("mthi55", 1'b1, 3'd5, 32'h55, 32'd0, 1'b0, 0, 32'h55, 32'd0);
      @(negedge clk);
      reset = 1'b1; md_valid = 1'b1; md_op = 3'd5; A = 32'hAA;
      @(negedge clk);
      reset = 1'b0; md_valid = 1'b0; md_op = 3'd0;
      chk("rst_vs_mthi.hi", hi, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX-stage instruction and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Generates the ID-stage stall for any md-class instruction (including mfhi/mflo) while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
md_valid  input  1  EX-stage instruction is a real (non-bubble) md write op
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
A  input  32  rs value after EX forwarding
B  input  32  rt value after EX forwarding
id_md_use  input  1  ID-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
start  output  1  combinational: md_valid & op in {1..4} & ~busy
busy  output  1  registered: operation in flight
stall  output  1  combinational: id_md_use & (start | busy)
hi  output  32  architectural HI, registered
lo  output  32  architectural LO, registered

Behaviour:
- Reset, synchronous: state IDLE, counter 0, pending HI/LO 0, hi 0, lo 0, busy 0.
  - Reset wins over every simultaneous event and aborts an in-flight op without committing it.
- States: IDLE, BUSY.
- IDLE:
  - If start is high in cycle T: latch operands, compute pending results, load counter with the latency, go to BUSY.
    - Latency is MULT_CYCLES for op 1/2, DIV_CYCLES for op 3/4.
  - Busy is high in cycles T+1 .. T+N.
- BUSY:
  - Counter decrements each cycle.
  - On the edge ending cycle T+N (counter==1): commit pending to hi/lo, busy drops, return to IDLE.
  - New hi/lo are visible from cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: same, unsigned.
  - div: lo = signed quotient truncated toward zero, hi = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: lo = 32'hFFFFFFFF, hi = A; busy still lasts DIV_CYCLES.
  - Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0.
- mthi/mtlo:
  - Accepted only when md_valid and not busy.
  - Write hi (or lo) = A at the edge ending that cycle; no busy period.
- md_valid with op 0 or 7: no effect.
- md_valid while busy:
  - Cannot occur, because stall holds the instruction in ID.
  - If it does occur, it is ignored. The bench flags it with an assertion.
- Stall:
  - Asserted in the start cycle and every busy cycle whenever ID holds an md-class instruction.
  - mfhi/mflo therefore always read committed values. No bypass of pending results.
- Non-md instructions proceed unstalled during busy.
- hi/lo change only at commit or mthi/mtlo edges.

Decomposition:
- Shared package/macro file:
  - md_op encodings 0..7.
  - Default latencies.
  - State encodings IDLE=1'b0, BUSY=1'b1.
- One natural sub-module, md_alu (combinational):
  - Inputs: op, A, B.
  - Outputs: 64-bit {hi,lo} result.
  - Covers signedness and the divide-by-zero/overflow rules.
  - The sequencer keeps the state, counter, pending and architectural registers.

Test Plan:
1. mult, A=-3 (0xFFFFFFFD), B=7 in cycle T:
   - start=1 in T; busy=1 in T+1..T+5.
   - hi=0xFFFFFFFF, lo=0xFFFFFFEB from T+6.
2. divu, A=100, B=7:
   - busy for 10 cycles.
   - lo=14, hi=2 afterwards.
   - id_md_use=1 (mflo in ID) throughout gives stall=1 for T..T+10 and 0 at T+11.
3. div, A=-7, B=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
4. div with B=0, A=0x1234: lo=0xFFFFFFFF, hi=0x1234 after 10 cycles.
5. mthi, A=0xDEADBEEF, while idle:
   - hi=0xDEADBEEF next cycle, busy never asserts.
   - Then mtlo, A=5: lo=5, hi unchanged.
6. multu, A=0xFFFFFFFF, B=2, reset=1 in busy cycle 3:
   - busy=0 and hi=lo=0 next cycle; no later commit occurs.
